// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: frame/line sequencing, ping-pong write enables and window-valid for two row buffers
module line_buffer_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WIDTH  = 1920
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_vid_VDE,
    input  logic                  i_vid_vsync,
    input  logic [3:0]            sw,
    output logic [1:0]            o_wea,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_sel,
    output logic [ADDR_WIDTH-1:0] o_col,
    output logic [ADDR_WIDTH-1:0] o_row,
    output logic                  o_win_valid,
    output logic [3:0]            o_mode,
    output logic [ADDR_WIDTH-1:0] o_line_len,
    output logic                  o_ovf
);
    typedef enum logic [1:0] {S_SYNC, S_BLANK, S_ACTIVE, S_SKIP} state_t;
    localparam logic [ADDR_WIDTH-1:0] MAXW = ADDR_WIDTH'(MAX_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] TWO  = ADDR_WIDTH'(2);
    state_t                state;
    logic                  vsync_q;
    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] row;
    logic                  vsync_rise;
    logic                  in_frame;
    logic                  room;
    logic                  accept;
    assign vsync_rise  = i_vid_vsync & ~vsync_q;
    assign in_frame    = state != S_SYNC;
    assign room        = col < MAXW;
    assign accept      = i_vid_VDE & in_frame & ~vsync_rise & room;
    // o_sel names the row N-1 buffer, so the write buffer is its complement
    assign o_wea       = accept ? (o_sel ? 2'b01 : 2'b10) : 2'b00;
    assign o_win_valid = accept & (row >= TWO) & (col >= TWO);
    assign o_addr      = col;
    assign o_col       = col;
    assign o_row       = row;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_SYNC;
            vsync_q    <= 1'b0;
            col        <= '0;
            row        <= '0;
            o_sel      <= 1'b0;
            o_mode     <= 4'd0;
            o_line_len <= '0;
            o_ovf      <= 1'b0;
        end else begin
            vsync_q <= i_vid_vsync;
            if (vsync_rise) begin
                state  <= S_BLANK;
                col    <= '0;
                row    <= '0;
                o_sel  <= 1'b1;
                o_mode <= sw;
            end else if (in_frame) begin
                if (i_vid_VDE) begin
                    if (room) begin
                        col   <= col + 1'b1;
                        state <= S_ACTIVE;
                    end else begin
                        o_ovf <= 1'b1;
                        state <= S_SKIP;
                    end
                end else if (state == S_ACTIVE || state == S_SKIP) begin
                    o_line_len <= col;
                    col        <= '0;
                    o_sel      <= ~o_sel;
                    row        <= (&row) ? row : row + 1'b1;
                    state      <= S_BLANK;
                end
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed and randomized checks of line_buffer_ctrl against a behavioural frame/line model
module tb_line_buffer_ctrl;
    localparam int AW = 11;
    localparam int MW = 16;
    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          i_vid_VDE = 1'b0;
    logic          i_vid_vsync = 1'b0;
    logic [3:0]    sw = 4'd0;
    logic [1:0]    o_wea;
    logic [AW-1:0] o_addr;
    logic          o_sel;
    logic [AW-1:0] o_col;
    logic [AW-1:0] o_row;
    logic          o_win_valid;
    logic [3:0]    o_mode;
    logic [AW-1:0] o_line_len;
    logic          o_ovf;

    line_buffer_ctrl #(.ADDR_WIDTH(AW), .MAX_WIDTH(MW)) dut (
        .clk(clk), .n_rst(n_rst), .i_vid_VDE(i_vid_VDE), .i_vid_vsync(i_vid_vsync), .sw(sw),
        .o_wea(o_wea), .o_addr(o_addr), .o_sel(o_sel), .o_col(o_col), .o_row(o_row),
        .o_win_valid(o_win_valid), .o_mode(o_mode), .o_line_len(o_line_len), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model: frame/line bookkeeping in plain integers
    bit m_framed, m_in_line, m_ovf, m_vs_prev, m_rise;
    int m_col, m_row, m_wbuf, m_mode, m_len;
    bit d_vde, d_vs;
    logic [3:0] d_sw;
    logic [52:0] exp_v;
    wire  [52:0] act_v = {o_wea, o_win_valid, o_addr, o_col, o_row, o_sel, o_mode, o_line_len, o_ovf};

    task automatic model_reset();
        m_framed = 0; m_in_line = 0; m_ovf = 0; m_vs_prev = 0;
        m_col = 0; m_row = 0; m_wbuf = 1; m_mode = 0; m_len = 0;
    endtask

    task automatic drive(input bit vde, input bit vs, input logic [3:0] s);
        bit acc;
        logic [1:0] e_wea;
        @(negedge clk);
        i_vid_VDE = vde; i_vid_vsync = vs; sw = s;
        d_vde = vde; d_vs = vs; d_sw = s;
        #1;
        m_rise = vs && !m_vs_prev;
        acc = m_framed && vde && !m_rise && m_col < MW;
        e_wea = acc ? ((m_wbuf == 0) ? 2'b01 : 2'b10) : 2'b00;
        exp_v = {e_wea, acc && m_row >= 2 && m_col >= 2, AW'(m_col), AW'(m_col), AW'(m_row),
                 1'(m_wbuf == 0), 4'(m_mode), AW'(m_len), m_ovf};
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_rise) begin
            m_framed = 1; m_col = 0; m_row = 0; m_wbuf = 0; m_mode = int'(d_sw); m_in_line = 0;
        end else if (m_framed) begin
            if (d_vde) begin
                if (m_col < MW) m_col++;
                else m_ovf = 1;
                m_in_line = 1;
            end else if (m_in_line) begin
                m_len = m_col; m_col = 0; m_wbuf ^= 1; m_in_line = 0;
                if (m_row < (1 << AW) - 1) m_row++;
            end
        end
        m_vs_prev = d_vs;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_rst = 1'b0; i_vid_VDE = 1'b0; i_vid_vsync = 1'b0; sw = 4'd0;
        #1;
        model_reset();
        checks++;
        if (act_v !== 53'd0) begin
            errors++;
            $display("FAIL reset outputs act %h exp 0", act_v);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_no_vsync();
        int wr = 0;
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 8; c++) begin
                drive(c < 5, 0, 4'd0);
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL no_vsync b%0d c%0d act %h exp %h", b, c, act_v, exp_v);
                end
                if (o_wea !== 2'b00) wr++;
                advance();
            end
        checks++;
        if (wr !== 0 || o_row !== '0) begin
            errors++;
            $display("FAIL no_vsync_wea writes %0d row %0d exp 0 0", wr, o_row);
        end
    endtask

    task automatic test_frame();
        int win = 0;
        drive(0, 1, 4'b0100); advance();
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 12; c++) begin
                drive(c < 8, 0, 4'b0100);
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL frame l%0d c%0d act %h exp %h", l, c, act_v, exp_v);
                end
                if (c < 8) begin
                    checks++;
                    if (o_addr !== AW'(c) || o_wea !== ((l % 2 == 0) ? 2'b01 : 2'b10) || o_row !== AW'(l)) begin
                        errors++;
                        $display("FAIL frame_px l%0d c%0d addr %0d wea %b row %0d", l, c, o_addr, o_wea, o_row);
                    end
                end
                if (o_win_valid === 1'b1) win++;
                advance();
            end
        checks++;
        if (win !== 6 || o_line_len !== AW'(8) || o_mode !== 4'b0100) begin
            errors++;
            $display("FAIL frame_sum win %0d len %0d mode %b exp 6 8 0100", win, o_line_len, o_mode);
        end
    endtask

    task automatic test_mode_hold();
        for (int c = 0; c < 8; c++) begin
            drive(c < 5, 0, 4'b0010);
            checks++;
            if (act_v !== exp_v || o_mode !== 4'b0100) begin
                errors++;
                $display("FAIL mode_hold c%0d act %h exp %h mode %b", c, act_v, exp_v, o_mode);
            end
            advance();
        end
        drive(0, 1, 4'b0010); advance();
        drive(0, 0, 4'b0010);
        checks++;
        if (act_v !== exp_v || o_mode !== 4'b0010) begin
            errors++;
            $display("FAIL mode_new act %h exp %h mode %b exp 0010", act_v, exp_v, o_mode);
        end
        advance();
    endtask

    task automatic test_overflow();
        int wr = 0;
        logic sel0;
        sel0 = o_sel;
        for (int c = 0; c < 23; c++) begin
            drive(c < 20, 0, 4'b0010);
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL overflow c%0d act %h exp %h", c, act_v, exp_v);
            end
            if (o_wea !== 2'b00) wr++;
            advance();
        end
        checks++;
        if (wr !== 16 || o_ovf !== 1'b1 || o_line_len !== AW'(16) || o_sel !== ~sel0) begin
            errors++;
            $display("FAIL overflow_sum wr %0d ovf %b len %0d sel %b exp 16 1 16 %b", wr, o_ovf, o_line_len, o_sel, ~sel0);
        end
    endtask

    task automatic test_vsync_midline();
        drive(0, 1, 4'd7); advance();
        for (int c = 0; c < 8; c++) begin drive(c < 6, 0, 4'd7); advance(); end
        for (int c = 0; c < 5; c++) begin drive(1, 0, 4'd7); advance(); end
        drive(1, 1, 4'd9);
        checks++;
        if (act_v !== exp_v || o_wea !== 2'b00 || o_col !== AW'(5) || o_row !== AW'(1)) begin
            errors++;
            $display("FAIL vsync_px act %h exp %h wea %b col %0d", act_v, exp_v, o_wea, o_col);
        end
        advance();
        drive(0, 1, 4'd9);
        checks++;
        if (act_v !== exp_v || o_col !== '0 || o_row !== '0 || o_sel !== 1'b1 || o_mode !== 4'd9) begin
            errors++;
            $display("FAIL vsync_after col %0d row %0d sel %b mode %0d exp 0 0 1 9", o_col, o_row, o_sel, o_mode);
        end
        advance();
    endtask

    task automatic test_reset_midline();
        drive(0, 0, 4'd3); advance();
        drive(0, 1, 4'd3); advance();
        for (int c = 0; c < 4; c++) begin drive(1, 0, 4'd3); advance(); end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act_v !== 53'd0) begin
            errors++;
            $display("FAIL reset_midline act %h exp 0", act_v);
        end
        i_vid_VDE = 1'b0; i_vid_vsync = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 24; c++) begin
            drive(c % 8 < 5, 0, 4'd3);
            checks++;
            if (act_v !== exp_v || o_wea !== 2'b00) begin
                errors++;
                $display("FAIL post_reset c%0d act %h exp %h", c, act_v, exp_v);
            end
            advance();
        end
        drive(0, 1, 4'd3); advance();
        for (int c = 0; c < 6; c++) begin
            drive(c < 4, 0, 4'd3);
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL resume c%0d act %h exp %h", c, act_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 149) < 2, 4'($urandom));
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random c%0d act %h exp %h", c, act_v, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_no_vsync();
        test_frame();
        test_mode_hold();
        test_overflow();
        test_vsync_midline();
        test_reset_midline();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencing controller for the two-row line-buffer pair that feeds the 3x3 window filters in the vid_io colour pipeline. It tracks frame and line boundaries from the video timing inputs and generates column write/read addresses and one-hot ping-pong write enables for the two row buffers. It also produces row/column position and a window-valid qualifier for the filter datapath. The filter mode is latched from `sw` only at frame start, so a mode change never tears a frame.

## Interface
- `ADDR_WIDTH`, 11: width of column/row counters and buffer address.
- `MAX_WIDTH`, 1920: buffer depth; maximum active pixels written per line.
- `clk` in 1: pixel clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `i_vid_VDE` in 1: active-pixel qualifier.
- `i_vid_vsync` in 1: vertical sync, active-high; its rising edge marks frame start.
- `sw` in 4: requested filter mode.
- `o_wea` out 2: one-hot write enable; bit b writes row buffer b.
- `o_addr` out ADDR_WIDTH: common write/read address for both buffers.
- `o_sel` out 1: index of the buffer holding row N-1; the other buffer holds row N-2.
- `o_col` out ADDR_WIDTH: column of the current pixel.
- `o_row` out ADDR_WIDTH: row index of the current line within the frame.
- `o_win_valid` out 1: the 3x3 window centred at (o_row-1, o_col-1) is fully inside the frame.
- `o_mode` out 4: `sw` latched at the last frame start.
- `o_line_len` out ADDR_WIDTH: active length of the last completed line, saturated at MAX_WIDTH.
- `o_ovf` out 1: sticky flag, set when any line exceeds MAX_WIDTH.

## Operation
- States:
  - S_SYNC: after reset.
  - S_BLANK: in frame, VDE low.
  - S_ACTIVE: writing.
  - S_SKIP: overflowed line.
- vsync_rise = `i_vid_vsync` & ~vsync_q, where vsync_q is registered.
- Frame start (vsync_rise, any state):
  - next state S_BLANK;
  - col, row, wsel <= 0;
  - `o_mode` <= `sw`.
  - Frame start overrides every other transition in the same cycle.
- S_SYNC: `o_wea`=0. VDE is ignored until the first vsync_rise.
- Pixel accept, S_BLANK or S_ACTIVE with VDE=1:
  - if col < MAX_WIDTH: `o_wea[wsel]`=1, col <= col+1, state S_ACTIVE;
  - if col == MAX_WIDTH: no write, `o_ovf` <= 1, state S_SKIP.
- End of line: VDE=0 while in S_ACTIVE or S_SKIP.
  - `o_line_len` <= col.
  - col <= 0.
  - wsel <= ~wsel.
  - row <= row+1, saturating at 2^ADDR_WIDTH-1.
  - State S_BLANK.
- `o_addr` = `o_col` = col. `o_sel` = ~wsel.
- Both buffers are read at `o_addr`. The buffer being written is required to be configured READ_FIRST, so that it returns row N-2 before the overwrite.
- `o_win_valid` = VDE & (state ≠ S_SYNC) & ~vsync_rise & row≥2 & col≥2 & col<MAX_WIDTH.
- Right and bottom edge centres are never flagged valid.
- The `o_ovf` flag is cleared only by reset.

## Timing
- Reset (asynchronous): state S_SYNC.
- Every register and output is 0 in reset, including `o_wea`, `o_win_valid`, `o_mode`, `o_sel`, `o_ovf`, `o_line_len`, `o_row`, `o_col`.
- `o_wea` and `o_win_valid` are combinational from `i_vid_VDE`, vsync_rise and registered state, with zero latency versus the pixel.
- All other outputs are registered.
- The first pixel of a line sees `o_addr`=0 in the same cycle.
- BRAM read data appears one cycle later; downstream aligns it.
- vsync_rise coinciding with VDE=1: `o_wea`=0 that cycle. The next cycle shows col=0, row=0.
- Deassertion of `n_rst` is synchronised externally. The block tolerates reset at any cycle, including mid-line.

## Test plan
- Reset, then 3 VDE bursts with no vsync edge -> `o_wea`=00 throughout, `o_row`=0.
- vsync rise with `sw`=4'b0100, then 3 lines of 8 pixels with 4 blank cycles between:
  - `o_mode`=0100;
  - `o_addr` 0..7 on each line;
  - `o_wea` 01, 10, 01 across the three lines;
  - `o_row` 0, 1, 2;
  - `o_line_len`=8;
  - `o_win_valid` high for exactly 6 cycles (cols 2..7 of row 2).
- `sw` changed to 4'b0010 mid-frame -> `o_mode` stays 0100 until the next vsync rise, then becomes 0010.
- MAX_WIDTH=16, one 20-pixel line:
  - `o_wea` high for 16 cycles;
  - `o_ovf`=1 from the cycle after the 17th pixel;
  - `o_line_len`=16;
  - `o_sel` toggles once.
- vsync rise during a pixel at col 5 -> `o_wea`=00 that cycle; next cycle `o_col`=0, `o_row`=0, `o_sel`=1.
- `n_rst` pulsed low mid-line -> all outputs 0 immediately; writes stay off until the next vsync rise.
